// File: rtl/mul32_seq.sv
// Sequential 32x32 -> 64-bit unsigned shift-and-add multiplier built around one ripple adder32.
// Optional build macro MUL32_ZERO_SKIP_EN: zero operands jump straight to DONE (latency 1).

module adder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [32:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_fa
            assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[32];
endmodule

module mul32_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     operand1,
    input  logic [WIDTH-1:0]     operand2,
    output logic                 res_valid,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy
);
    // The datapath is hard-wired to the 32-bit adder; any other width cannot work.
    generate
        if (WIDTH != 32) begin : g_width_err
            $error("mul32_seq: WIDTH must be 32");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] mcand_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    logic [4:0]  cnt_reg;

    logic [31:0] addend;
    logic [31:0] sum;
    logic        cout;
    logic        accept;
    logic        zero_op;

    assign addend = mcand_reg & {32{lo_reg[0]}};

    adder32 u_adder (
        .a    (hi_reg),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    assign accept = in_valid && (state_reg == IDLE);

`ifdef MUL32_ZERO_SKIP_EN
    assign zero_op = (operand1 == 32'd0) || (operand2 == 32'd0);
`else
    assign zero_op = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        busy       = 1'b0;
        res_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = zero_op ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (cnt_reg == 5'd31) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                res_valid  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // {c,sum,lo} shifted right by one: the adder carry lands in hi[31], sum[0] in lo[31].
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_reg <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            cnt_reg   <= '0;
        end else begin
            if (accept) begin
                mcand_reg <= operand1;
                hi_reg    <= '0;
                lo_reg    <= zero_op ? 32'd0 : operand2;
                cnt_reg   <= '0;
            end else if (state_reg == CALC) begin
                hi_reg  <= {cout, sum[31:1]};
                lo_reg  <= {sum[0], lo_reg[31:1]};
                cnt_reg <= cnt_reg + 5'd1;
            end
        end
    end

    assign result = {hi_reg, lo_reg};
endmodule
